// File: rtl/spi_share_arbiter.sv
// Two-requester SPI bus share: the USB host (req 0, IO[10]) and the SD card
// (req 1, IO[6]) share SCLK/MOSI/MISO. A whole transaction is held under one
// chip-select. Pending requesters are served round-robin, and bytes move
// through a mode-0, MSB-first shifter whose clock divider follows the owner.
module spi_share_arbiter #(
  parameter int DIV_USB     = 2,
  parameter int DIV_SD_SLOW = 64,
  parameter int DIV_SD_FAST = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  req,
  output logic [1:0]  gnt,
  input  logic [1:0]  byte_valid,
  input  logic [15:0] byte_tx,
  output logic        byte_ready,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  input  logic        sd_fast,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic [1:0]  cs_n
);

  localparam logic [7:0] DIV_USB_C  = 8'(DIV_USB);
  localparam logic [7:0] DIV_SLOW_C = 8'(DIV_SD_SLOW);
  localparam logic [7:0] DIV_FAST_C = 8'(DIV_SD_FAST);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_READY,
    S_SHIFT,
    S_RELEASE
  } state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        rr_last_q, rr_last_d;
  logic [7:0]  div_q, div_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  half_q, half_d;
  logic        sclk_q, sclk_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  rx_sr_q, rx_sr_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;

  logic        cnt_done;
  logic        win;
  logic        owned;

  assign cnt_done = (cnt_q == div_q - 8'd1);

  // Next-state logic: arbitration, setup/guard timing and the byte shifter.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_last_d  = rr_last_q;
    div_d      = div_q;
    cnt_d      = cnt_q;
    half_d     = half_q;
    sclk_d     = sclk_q;
    tx_d       = tx_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    win        = (req == 2'b11) ? ~rr_last_q : req[1];

    case (state_q)
      S_IDLE: begin
        if (req != 2'b00) begin
          owner_d   = win;
          rr_last_d = win;
          // The divider is frozen here; sd_fast is ignored for the rest of the grant.
          div_d     = win ? (sd_fast ? DIV_FAST_C : DIV_SLOW_C) : DIV_USB_C;
          cnt_d     = 8'd0;
          state_d   = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_done) begin
          cnt_d   = 8'd0;
          state_d = S_READY;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_READY: begin
        // A dropped request wins over a byte offered in the same cycle.
        if (!req[owner_q]) begin
          cnt_d   = 8'd0;
          state_d = S_RELEASE;
        end else if (byte_valid[owner_q]) begin
          tx_d    = owner_q ? byte_tx[15:8] : byte_tx[7:0];
          cnt_d   = 8'd0;
          half_d  = 4'd0;
          sclk_d  = 1'b0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (cnt_done) begin
          cnt_d  = 8'd0;
          half_d = half_q + 4'd1;
          if (half_q == 4'd15) begin
            // Final falling edge: no shift, hand the byte back.
            sclk_d     = 1'b0;
            rx_data_d  = rx_sr_q;
            rx_valid_d = 1'b1;
            state_d    = S_READY;
          end else begin
            sclk_d = ~sclk_q;
            if (!sclk_q) begin
              rx_sr_d = {rx_sr_q[6:0], spi_miso};
            end else begin
              tx_d = {tx_q[6:0], 1'b1};
            end
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RELEASE: begin
        if (cnt_done) begin
          cnt_d   = 8'd0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset leaves the bus idle with USB favoured.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      owner_q    <= 1'b0;
      rr_last_q  <= 1'b1;
      div_q      <= DIV_USB_C;
      cnt_q      <= 8'd0;
      half_q     <= 4'd0;
      sclk_q     <= 1'b0;
      tx_q       <= 8'hFF;
      rx_sr_q    <= 8'd0;
      rx_data_q  <= 8'd0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_last_q  <= rr_last_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      half_q     <= half_d;
      sclk_q     <= sclk_d;
      tx_q       <= tx_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  // Outputs decode from registered state, so reset takes effect immediately.
  always_comb begin
    owned      = (state_q == S_SETUP) || (state_q == S_READY) || (state_q == S_SHIFT);
    gnt        = owned ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    cs_n       = ~gnt;
    byte_ready = (state_q == S_READY);
    spi_sclk   = sclk_q;
    spi_mosi   = (state_q == S_SHIFT) ? tx_q[7] : 1'b1;
    rx_valid   = rx_valid_q;
    rx_data    = rx_data_q;
  end

endmodule
